// File: rtl/dma_engineer.sv
// dma_engineer: responder side of the layer weight-fetch DMA handshake.
// Takes one request (start address + length in words), acknowledges it, issues
// word reads to the memory read port and streams the returned words back to
// the requester with en/eop strobes. There is no output backpressure.
//
// Optional feature macro: DMA_ADDR_CHECK_EN
//   When defined, a request whose range runs past MEM_WORDS issues no reads,
//   completes immediately and sets the sticky dma_err flag.
//   When undefined, addresses wrap mod 2^ADDR_W and dma_err is tied 0.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   dma_engineer_req/start_addr/length   request (held until ack)
//   dma_engineer_ack              one-cycle acknowledge
//   dma_engineer_dout/_en/_eop    returned word stream
//   mem_rd_cmd_en/_addr/_rdy      read command handshake
//   mem_rd_data/_en               read data, in command order
//   dma_busy, dma_done, dma_err   status
module dma_engineer #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MEM_WORDS       = 134217728
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic              dma_engineer_ack,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_rd_cmd_en,
  output logic [ADDR_W-1:0] mem_rd_cmd_addr,
  input  logic              mem_rd_cmd_rdy,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_data_en,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ACK, RUN, DONE} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_start, r_len, r_issued, r_received;
  logic [OUT_W-1:0]    r_outstanding;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dout_en, r_dout_eop;
  logic                w_cmd_acc, w_data_acc, w_last_beat, w_addr_bad;

  assign w_cmd_acc   = mem_rd_cmd_en && mem_rd_cmd_rdy;
  // Data with nothing in flight (e.g. stragglers after a reset) is dropped.
  assign w_data_acc  = mem_rd_data_en && (r_outstanding != '0);
  assign w_last_beat = (r_received == r_len - 1'b1);

`ifdef DMA_ADDR_CHECK_EN
  logic [ADDR_W:0] w_end;
  logic            r_err;
  // One extra bit so a range that crosses 2^ADDR_W is seen as out of range.
  assign w_end      = {1'b0, r_start} + {1'b0, r_len};
  assign w_addr_bad = (w_end > (ADDR_W+1)'(MEM_WORDS));
  assign dma_err    = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_err <= 1'b0;
    else if (r_state == ACK && w_addr_bad) r_err <= 1'b1;
  end
`else
  logic w_unused_mem_words;
  assign w_unused_mem_words = (MEM_WORDS != 0);
  assign w_addr_bad         = 1'b0;
  assign dma_err            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (dma_engineer_req) w_next = ACK;
      ACK:  w_next = (r_len == '0 || w_addr_bad) ? DONE : RUN;
      // eop is registered, so the transfer closes the cycle after it is driven.
      RUN:  if (r_dout_eop) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dma_engineer_ack = 1'b0;
    dma_busy         = 1'b0;
    dma_done         = 1'b0;
    mem_rd_cmd_en    = 1'b0;
    mem_rd_cmd_addr  = r_start + r_issued;
    case (r_state)
      ACK: begin
        dma_engineer_ack = 1'b1;
        dma_busy         = 1'b1;
      end
      RUN: begin
        dma_busy      = 1'b1;
        // Only outstanding can block issue, and it only falls while a command
        // waits, so en/addr stay stable until accepted.
        mem_rd_cmd_en = (r_issued < r_len) &&
                        (r_outstanding < OUT_W'(MAX_OUTSTANDING));
      end
      DONE:    dma_done = 1'b1;
      default: ;
    endcase
  end

  assign dma_engineer_dout     = r_dout;
  assign dma_engineer_dout_en  = r_dout_en;
  assign dma_engineer_dout_eop = r_dout_eop;

  // Datapath and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start       <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_dout        <= '0;
      r_dout_en     <= 1'b0;
      r_dout_eop    <= 1'b0;
    end else begin
      r_dout_en  <= w_data_acc;
      r_dout_eop <= w_data_acc && w_last_beat;
      if (w_data_acc) r_dout <= mem_rd_data;

      if (r_state == IDLE && dma_engineer_req) begin
        r_start    <= dma_engineer_start_addr;
        r_len      <= dma_engineer_length;
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        if (w_cmd_acc)  r_issued   <= r_issued + 1'b1;
        if (w_data_acc) r_received <= r_received + 1'b1;
      end

      case ({w_cmd_acc, w_data_acc})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engineer.sv
module tb_dma_engineer;
  localparam int AW   = 27;
  localparam int DW   = 64;
  localparam int MAXO = 4;
  localparam int MEMW = 134217728;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [AW-1:0] start_addr, length;
  logic          ack;
  logic [DW-1:0] dout;
  logic          dout_en, dout_eop;
  logic          cmd_en;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_en;
  logic          busy, done, err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] seed;

  int unsigned   mq_due[$];
  logic [AW-1:0] mq_addr[$];

  always #5 clk = ~clk;

  dma_engineer #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .MEM_WORDS(MEMW)) dut (
    .clk(clk), .rst(rst),
    .dma_engineer_req(req), .dma_engineer_start_addr(start_addr),
    .dma_engineer_length(length), .dma_engineer_ack(ack),
    .dma_engineer_dout(dout), .dma_engineer_dout_en(dout_en),
    .dma_engineer_dout_eop(dout_eop),
    .mem_rd_cmd_en(cmd_en), .mem_rd_cmd_addr(cmd_addr), .mem_rd_cmd_rdy(cmd_rdy),
    .mem_rd_data(rd_data), .mem_rd_data_en(rd_data_en),
    .dma_busy(busy), .dma_done(done), .dma_err(err)
  );

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return {seed ^ a32, (a32 * 32'h9E3779B1) ^ 32'h5A5A0000};
  endfunction

  // One transfer against a memory model with fixed latency.
  // mode: 0 rdy always 1, 1 rdy pattern 1,0,0,..., 2 random rdy.
  // abort_beats>0: pulse rst once that many beats have been seen.
  task automatic run_xfer(input logic [AW-1:0] st, input logic [AW-1:0] len,
                          input int lat, input int mode, input int abort_beats,
                          input bit exp_err, input string name);
    int ack_cnt = 0, ack_cyc = -1, beats = 0, issued = 0, done_cnt = 0;
    int done_cyc = -1, eop_cyc = -1, inflight = 0, first_cmd = -1, exp_len;
    bit prev_en = 0, prev_acc = 0, aborted = 0, exp_eop;
    logic [AW-1:0] prev_addr = '0, ea;
    exp_len = exp_err ? 0 : int'(len);
    mq_due.delete(); mq_addr.delete();
    @(negedge clk);
    req = 1'b1; start_addr = st; length = len;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (ack) begin
        ack_cnt++; if (ack_cnt == 1) ack_cyc = cyc;
        req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_at_ack got=%b exp=1", name, busy); end
      end
      if (dout_en) begin
        ea = st + AW'(beats);
        exp_eop = (beats == exp_len - 1);
        checks++;
        if (beats >= exp_len || dout !== word_of(ea) || dout_eop !== exp_eop) begin
          failures++;
          $display("FAIL %s beat%0d got=%h/eop%b exp=%h/eop%b", name, beats, dout, dout_eop, word_of(ea), exp_eop);
        end
        if (dout_eop) eop_cyc = cyc;
        beats++;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b exp=0", name, busy); end
      end
      if (inflight >= MAXO) begin
        checks++;
        if (cmd_en !== 1'b0) begin failures++; $display("FAIL %s max_outstanding cmd_en=%b inflight=%0d", name, cmd_en, inflight); end
      end
      if (prev_en && !prev_acc) begin
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== prev_addr) begin
          failures++; $display("FAIL %s cmd_hold got=%b/%h exp=1/%h", name, cmd_en, cmd_addr, prev_addr);
        end
      end
      case (mode)
        0: cmd_rdy = 1'b1;
        1: cmd_rdy = (cyc % 3 == 0);
        default: cmd_rdy = 1'($urandom_range(0, 1));
      endcase
      prev_en = cmd_en; prev_addr = cmd_addr; prev_acc = cmd_en && cmd_rdy;
      if (cmd_en && cmd_rdy) begin
        ea = st + AW'(issued);
        if (first_cmd < 0) first_cmd = cyc;
        checks++;
        if (issued >= exp_len || cmd_addr !== ea) begin
          failures++; $display("FAIL %s cmd%0d addr got=%h exp=%h", name, issued, cmd_addr, ea);
        end
        issued++; inflight++;
        mq_due.push_back(cyc + lat); mq_addr.push_back(cmd_addr);
      end
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        rd_data_en = 1'b1; rd_data = word_of(mq_addr[0]);
        void'(mq_due.pop_front()); void'(mq_addr.pop_front()); inflight--;
      end else begin
        rd_data_en = 1'b0; rd_data = {$urandom, $urandom};
      end
      if (abort_beats > 0 && beats == abort_beats) begin aborted = 1; break; end
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
    end
    if (aborted) begin
      rst = 1'b1;
      #1;
      checks++;
      if ({ack, cmd_en, dout_en, dout_eop, busy, done, err} !== 7'b0 || dout !== '0) begin
        failures++; $display("FAIL %s abort_outputs got=%b%b%b%b%b%b%b dout=%h exp=0", name,
                             ack, cmd_en, dout_en, dout_eop, busy, done, err, dout);
      end
      cmd_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({dout_en, cmd_en, busy, ack, done} !== 5'b0) begin
          failures++; $display("FAIL %s late_data got=%b%b%b%b%b exp=00000", name, dout_en, cmd_en, busy, ack, done);
        end
        // Stragglers from the aborted transfer keep arriving.
        rd_data_en = (k < 6); rd_data = {$urandom, $urandom};
      end
    end else begin
      checks++;
      if (ack_cnt != 1 || ack_cyc != 0) begin failures++; $display("FAIL %s ack got=%0d@%0d exp=1@0", name, ack_cnt, ack_cyc); end
      checks++;
      if (beats != exp_len || issued != exp_len) begin
        failures++; $display("FAIL %s counts beats=%0d cmds=%0d exp=%0d", name, beats, issued, exp_len);
      end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt); end
      checks++;
      if (exp_len > 0) begin
        if (done_cyc != eop_cyc + 1) begin failures++; $display("FAIL %s done_after_eop got=%0d exp=%0d", name, done_cyc, eop_cyc + 1); end
      end else if (done_cyc - ack_cyc < 1 || done_cyc - ack_cyc > 2) begin
        failures++; $display("FAIL %s done_after_ack got=%0d exp=1..2", name, done_cyc - ack_cyc);
      end
      if (mode == 0 && exp_len > 0) begin
        checks++;
        if (first_cmd != 1) begin failures++; $display("FAIL %s first_cmd got=%0d exp=1", name, first_cmd); end
      end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL %s dma_err got=%b exp=%b", name, err, exp_err); end
    end
    rd_data_en = 1'b0; cmd_rdy = 1'b0; req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, cmd_en, dout_en, dout_eop, busy, done, err} !== 7'b0 || dout !== '0) begin
      failures++; $display("FAIL reset got=%b%b%b%b%b%b%b dout=%h exp=0", ack, cmd_en, dout_en, dout_eop, busy, done, err, dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();        run_xfer(27'd0,   27'd2,  3,  0, 0, 1'b0, "basic");       endtask
  task automatic test_single();       run_xfer(27'd100, 27'd1,  2,  0, 0, 1'b0, "single");      endtask
  task automatic test_rdy_toggle();   run_xfer(27'd0,   27'd5,  2,  1, 0, 1'b0, "rdy_toggle");  endtask
  task automatic test_outstanding();  run_xfer(27'd40,  27'd10, 20, 0, 0, 1'b0, "outstanding"); endtask
  task automatic test_zero_len();     run_xfer(27'd7,   27'd0,  1,  0, 0, 1'b0, "zero_len");    endtask

  task automatic test_abort();
    run_xfer(27'd200, 27'd8, 2, 0, 3, 1'b0, "abort");
    run_xfer(27'd300, 27'd2, 3, 0, 0, 1'b0, "after_abort");
  endtask

  // Data with nothing in flight must not reach the stream.
  task automatic test_stray();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (dout_en !== 1'b0) begin failures++; $display("FAIL stray dout_en got=%b exp=0", dout_en); end
      end
      rd_data_en = (k < 3); rd_data = {$urandom, $urandom};
    end
    rd_data_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_xfer(AW'($urandom_range(0, 1 << 26)), AW'($urandom_range(1, 12)),
               int'($urandom_range(1, 20)), int'($urandom_range(0, 2)), 0, 1'b0, "random");
  endtask

`ifdef DMA_ADDR_CHECK_EN
  task automatic test_addr_check();
    run_xfer(AW'(MEMW - 3), 27'd8, 3, 0, 0, 1'b1, "addr_err");
    run_xfer(27'd0, 27'd2, 3, 0, 0, 1'b1, "err_sticky");
  endtask
`else
  task automatic test_wrap();
    run_xfer(AW'(MEMW - 2), 27'd4, 2, 0, 0, 1'b0, "wrap");
  endtask
`endif

  initial begin
    seed = $urandom;
    rst = 1'b1; req = 1'b0; start_addr = '0; length = '0;
    cmd_rdy = 1'b0; rd_data = '0; rd_data_en = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_rdy_toggle();
    test_outstanding();
    test_zero_len();
    test_stray();
    test_abort();
    test_random();
`ifdef DMA_ADDR_CHECK_EN
    test_addr_check();
`else
    test_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
